// File: rtl/cpu_dcache.sv
// Direct-mapped, write-through, read-allocate data cache between the memory stage
// and a word-addressed backing memory, with saturating read hit/miss counters.
module cpu_dcache #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int LINES  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WIDTH-1:0]  resp_rdata,
    output logic              hit,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t             state, state_nxt;
    logic [LINES-1:0]   line_vld;
    logic [TAG_W-1:0]   line_tag  [LINES];
    logic [WIDTH-1:0]   line_data [LINES];

    logic [IDX_W-1:0]   req_idx, mem_idx;
    logic [TAG_W-1:0]   req_tag, mem_tag;
    logic               lookup_hit;
    logic               accept;
    logic               fill;
    logic               wr_done;
    logic               wr_hit_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign req_idx    = req_addr[IDX_W-1:0];
    assign req_tag    = req_addr[ADDR_W-1:IDX_W];
    assign mem_idx    = mem_addr[IDX_W-1:0];
    assign mem_tag    = mem_addr[ADDR_W-1:IDX_W];
    assign lookup_hit = line_vld[req_idx] && (line_tag[req_idx] == req_tag);
    assign accept     = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        fill      = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst && !flush;
                if (req_valid && rst && !flush) begin
                    if (req_we)           state_nxt = WR_THRU;
                    else if (!lookup_hit) state_nxt = RD_MISS;
                end
            end
            RD_MISS: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_THRU: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accept stage: lookup result turns into a response or a memory transaction next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_vld   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            hit        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wr_hit_p1  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            if (state == IDLE && flush) line_vld <= '0;
            if (accept) begin
                mem_we   <= req_we;
                mem_addr <= req_addr;
                if (req_we) begin
                    mem_wdata <= req_wdata;
                    wr_hit_p1 <= lookup_hit;
                end else if (lookup_hit) begin
                    resp_valid <= 1'b1;
                    hit        <= 1'b1;
                    resp_rdata <= line_data[req_idx];
                    hit_count  <= sat_inc(hit_count);
                end else begin
                    miss_count <= sat_inc(miss_count);
                end
            end
            if (fill) begin
                line_vld[mem_idx] <= 1'b1;
                resp_valid        <= 1'b1;
                resp_rdata        <= mem_rdata;
            end
            if (wr_done) begin
                resp_valid <= 1'b1;
                resp_rdata <= '0;
                hit        <= wr_hit_p1;
            end
        end
    end

    // Tag/data arrays carry no reset; validity alone decides whether a line is usable
    always_ff @(posedge clk) begin
        if (accept && req_we && lookup_hit) line_data[req_idx] <= req_wdata;
        if (fill) begin
            line_tag[mem_idx]  <= mem_tag;
            line_data[mem_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cpu_dcache.sv
// Directed bench for cpu_dcache: default configuration plus a CNT_W=2 copy
// sharing the same stimulus to exercise counter saturation.
module tb_cpu_dcache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        flush = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        req_ready, resp_valid, hit, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_wdata;
    logic [4:0]  mem_addr;
    logic [15:0] hit_count, miss_count;

    logic        s_req_ready, s_resp_valid, s_hit, s_mem_req, s_mem_we;
    logic [31:0] s_resp_rdata, s_mem_wdata;
    logic [4:0]  s_mem_addr;
    logic [1:0]  s_hit_count, s_miss_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_dcache dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .hit(hit), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cpu_dcache #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(s_req_ready), .resp_valid(s_resp_valid),
        .resp_rdata(s_resp_rdata), .hit(s_hit), .flush(flush), .mem_req(s_mem_req),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    // One request; memory acks ack_dly cycles after mem_req first appears.
    task automatic xact(input logic we, input logic [4:0] a, input logic [31:0] wd,
                        input int ack_dly, input logic [31:0] mval,
                        output logic o_rv, output logic o_hit, output logic [31:0] o_rdata,
                        output int o_mreq, output logic o_mwe, output logic [4:0] o_maddr,
                        output logic [31:0] o_mwdata);
        int cyc;
        o_mreq = 0; o_mwe = 1'b0; o_maddr = '0; o_mwdata = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!resp_valid && cyc < 40) begin
            if (mem_req) begin
                o_mreq++;
                o_mwe = mem_we; o_maddr = mem_addr; o_mwdata = mem_wdata;
                mem_ack = (o_mreq == ack_dly + 1);
                mem_rdata = mval;
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        o_rv = resp_valid; o_hit = hit; o_rdata = resp_rdata;
    endtask

    logic        rv, rh, mwe;
    logic [31:0] rd, mwd;
    logic [4:0]  ma;
    int          nreq;

    task automatic test_reset();
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0h exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0 || hit !== 1'b0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp got=%0h/%0h/%0h exp=0/0/0", resp_valid, hit, resp_rdata); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 5'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem got=%0h/%0h/%0h/%0h exp=0", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0/0", hit_count, miss_count); end
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%0h exp=1", req_ready); end
    endtask

    task automatic test_read_miss();
        xact(1'b0, 5'd3, 32'h0, 2, 32'h11, rv, rh, rd, nreq, mwe, ma, mwd);
        checks++; if (nreq !== 3) begin failures++; $display("FAIL miss_memreq_cycles got=%0d exp=3", nreq); end
        checks++; if (ma !== 5'd3 || mwe !== 1'b0) begin failures++; $display("FAIL miss_memaddr got=%0h/%0h exp=3/0", ma, mwe); end
        checks++; if (rv !== 1'b1 || rh !== 1'b0 || rd !== 32'h11) begin failures++; $display("FAIL miss_resp got=%0h/%0h/%0h exp=1/0/11", rv, rh, rd); end
        checks++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin failures++; $display("FAIL miss_cnt got=%0d/%0d exp=1/0", miss_count, hit_count); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd3;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || hit !== 1'b1 || resp_rdata !== 32'h11 || mem_req !== 1'b0) begin failures++; $display("FAIL b2b_first got=%0h/%0h/%0h/%0h exp=1/1/11/0", resp_valid, hit, resp_rdata, mem_req); end
        @(negedge clk); req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || hit !== 1'b1 || resp_rdata !== 32'h11 || mem_req !== 1'b0) begin failures++; $display("FAIL b2b_second got=%0h/%0h/%0h/%0h exp=1/1/11/0", resp_valid, hit, resp_rdata, mem_req); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || hit !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0h/%0h exp=0/0", resp_valid, hit); end
        checks++; if (hit_count !== 16'd2 || miss_count !== 16'd1) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=2/1", hit_count, miss_count); end
    endtask

    task automatic test_write_through();
        xact(1'b1, 5'd3, 32'h55, 0, 32'h0, rv, rh, rd, nreq, mwe, ma, mwd);
        checks++; if (nreq !== 1 || mwe !== 1'b1 || ma !== 5'd3 || mwd !== 32'h55) begin failures++; $display("FAIL wr_mem got=%0d/%0h/%0h/%0h exp=1/1/3/55", nreq, mwe, ma, mwd); end
        checks++; if (rv !== 1'b1 || rh !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL wr_hit_resp got=%0h/%0h/%0h exp=1/1/0", rv, rh, rd); end
        checks++; if (hit_count !== 16'd2 || miss_count !== 16'd1) begin failures++; $display("FAIL wr_cnt got=%0d/%0d exp=2/1", hit_count, miss_count); end
        xact(1'b0, 5'd3, 32'h0, 0, 32'hdead, rv, rh, rd, nreq, mwe, ma, mwd);
        checks++; if (rv !== 1'b1 || rh !== 1'b1 || rd !== 32'h55 || nreq !== 0) begin failures++; $display("FAIL rd_after_wr got=%0h/%0h/%0h/%0d exp=1/1/55/0", rv, rh, rd, nreq); end
        xact(1'b1, 5'd11, 32'h66, 1, 32'h0, rv, rh, rd, nreq, mwe, ma, mwd);
        checks++; if (rv !== 1'b1 || rh !== 1'b0 || nreq !== 2 || ma !== 5'd11 || mwd !== 32'h66) begin failures++; $display("FAIL wr_miss got=%0h/%0h/%0d/%0h/%0h exp=1/0/2/b/66", rv, rh, nreq, ma, mwd); end
        xact(1'b0, 5'd3, 32'h0, 0, 32'hdead, rv, rh, rd, nreq, mwe, ma, mwd);
        checks++; if (rv !== 1'b1 || rh !== 1'b1 || rd !== 32'h55) begin failures++; $display("FAIL rd_after_wrmiss got=%0h/%0h/%0h exp=1/1/55", rv, rh, rd); end
        checks++; if (hit_count !== 16'd4 || miss_count !== 16'd1) begin failures++; $display("FAIL wr_seq_cnt got=%0d/%0d exp=4/1", hit_count, miss_count); end
    endtask

    task automatic test_flush();
        @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd3; flush = 1'b1; #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0h exp=0", req_ready); end
        @(negedge clk); req_valid = 1'b0; flush = 1'b0;
        checks++; if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL flush_not_taken got=%0h/%0h exp=0/0", resp_valid, mem_req); end
        xact(1'b0, 5'd3, 32'h0, 0, 32'h55, rv, rh, rd, nreq, mwe, ma, mwd);
        checks++; if (rv !== 1'b1 || rh !== 1'b0 || rd !== 32'h55 || nreq !== 1) begin failures++; $display("FAIL flush_rd_miss got=%0h/%0h/%0h/%0d exp=1/0/55/1", rv, rh, rd, nreq); end
        checks++; if (miss_count !== 16'd2 || hit_count !== 16'd4) begin failures++; $display("FAIL flush_cnt got=%0d/%0d exp=2/4", miss_count, hit_count); end
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
        @(negedge clk); req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_memreq got=%0h exp=1", mem_req); end
        #2 rst = 1'b0; #1;
        checks++; if (mem_req !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_drop got=%0h/%0h exp=0/0", mem_req, req_ready); end
        checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin failures++; $display("FAIL mid_reset_cnt got=%0d/%0d exp=0/0", hit_count, miss_count); end
        @(negedge clk); rst = 1'b1;
        xact(1'b0, 5'd3, 32'h0, 0, 32'h55, rv, rh, rd, nreq, mwe, ma, mwd);
        checks++; if (rv !== 1'b1 || rh !== 1'b0 || rd !== 32'h55 || miss_count !== 16'd1) begin failures++; $display("FAIL post_reset_miss got=%0h/%0h/%0h/%0d exp=1/0/55/1", rv, rh, rd, miss_count); end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 5; i++) begin
            xact(1'b0, 5'd3, 32'h0, 0, 32'hdead, rv, rh, rd, nreq, mwe, ma, mwd);
            checks++; if (rh !== 1'b1 || hit_count !== 16'(i)) begin failures++; $display("FAIL sat_main_hit%0d got=%0h/%0d exp=1/%0d", i, rh, hit_count, i); end
            checks++; if (s_hit_count !== 2'((i > 3) ? 3 : i)) begin failures++; $display("FAIL sat_hit%0d got=%0d exp=%0d", i, s_hit_count, (i > 3) ? 3 : i); end
        end
        checks++; if (s_miss_count !== 2'd1) begin failures++; $display("FAIL sat_miss got=%0d exp=1", s_miss_count); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_back_to_back();
        test_write_through();
        test_flush();
        test_reset_mid_miss();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
